ex_divider: RTL
===============

Name: ex_divider

Overview:
- Multi-cycle integer divider in the EX stage.
- Consumes the ALU function code generated in ID and carried through the ID/EX register, together with the two register operands.
- On DIV/DIVU it runs a 32-iteration restoring division, holds the pipeline via a stall request, then presents quotient/remainder for the HI/LO write path.
- All other function codes pass through untouched (block stays idle).

Parameters:
- DATA_WIDTH, 32, operand/result width.
- CNT_WIDTH, 6, iteration counter width; must hold DATA_WIDTH.
- FUNCT_DIV, 6'h1A, signed divide code (matches funct definitions).
- FUNCT_DIVU, 6'h1B, unsigned divide code.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- valid  in  1  EX holds a live instruction this cycle
- funct  in  6  ALU function code from ID/EX register
- operand_a  in  DATA_WIDTH  dividend (rs)
- operand_b  in  DATA_WIDTH  divisor (rt)
- flush  in  1  pipeline flush/exception; cancels any division
- stall_in  in  1  downstream (MEM) stall; pipeline cannot advance
- stall_req  out  1  request to freeze IF/ID/EX
- done  out  1  hi/lo valid for the instruction in EX
- hi  out  DATA_WIDTH  remainder
- lo  out  DATA_WIDTH  quotient

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE; done=0; hi=0; lo=0; counter=0; internal registers cleared.
  - stall_req=0 in the cycle after reset.
- start = valid & ~flush & (funct==FUNCT_DIV | funct==FUNCT_DIVU); evaluated only in IDLE.
- stall_req (combinational):
  - 1 when (IDLE & start) or state==BUSY.
  - 0 in DONE, and 0 whenever flush=1.
- States:
  - IDLE:
    - On start with operand_b==0: go to DONE with lo=all-ones, hi=operand_a (no iteration).
    - On start otherwise: latch signedness; latch |a| and |b| (signed) or raw (unsigned); latch quotient sign = a[MSB]^b[MSB] and remainder sign = a[MSB] (signed only); clear partial remainder (DATA_WIDTH+1 bits) and counter; go to BUSY.
  - BUSY:
    - One restoring step per cycle: shift {rem,quot} left 1, trial-subtract divisor, set quotient LSB=1 if no borrow, else restore.
    - Counter increments; after the DATA_WIDTH-th step go to DONE.
    - On that final transition, write sign-corrected results to lo/hi (two's complement negate where sign flag set).
  - DONE:
    - done=1, hi/lo stable.
    - If stall_in=1, remain DONE (results held).
    - Else go to IDLE.
    - done is 0 in every other state.
- Latency, start in cycle 0:
  - Normal: stall_req high cycles 0..32, done=1 in cycle 33.
  - Divide-by-zero: stall_req high cycle 0, done=1 in cycle 1.
- No restart from DONE: the held DIV in EX during DONE is not re-sampled. The next start is recognised only in IDLE, i.e. the cycle after DONE exits.
- flush=1 in any state:
  - Next state IDLE, done=0 next cycle.
  - hi/lo keep their previous values (not written).
  - flush overrides start in the same cycle.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (natural wrap of the magnitude algorithm, no trap).
- Signed results:
  - Quotient truncates toward zero.
  - Remainder takes the dividend's sign.
  - Invariant: a = q*b + r.
- Operands may change after cycle 0; only latched copies are used.
- Non-divide funct, or valid=0: no state change, stall_req=0.
- rst mid-BUSY or in DONE: immediate return to reset values at that edge.

Test Plan:
- DIVU 100/7, start cycle 0 -> stall_req=1 cycles 0-32; done=1 cycle 33; lo=14, hi=2; IDLE cycle 34.
- DIV 0xFFFFFFF9(-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7/0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
- DIVU 0x1234/0 -> done=1 in cycle 1, lo=0xFFFFFFFF, hi=0x1234, stall_req only in cycle 0.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0 at cycle 33. DIVU 0xFFFFFFFF/1 -> lo=0xFFFFFFFF, hi=0.
- Start DIVU 50/3, flush in cycle 10 -> stall_req=0 in cycle 10, IDLE cycle 11, no done pulse, hi/lo unchanged. Then DIVU 9/4 -> lo=2, hi=1 after 33 cycles.
- DIVU 20/6 with stall_in=1 cycles 33-35 -> done=1 cycles 33-36, lo=3, hi=2 stable, no restart. IDLE cycle 37. Also: rst asserted in cycle 15 of a division -> all outputs 0 next cycle.

Source files
------------

// File: rtl/ex_divider_if.sv
// EX-stage divider bus: operands and control in from ID/EX, hi/lo and
// stall/done back to the pipeline.
interface ex_divider_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  valid;
   logic [5:0]            funct;
   logic [DATA_WIDTH-1:0] operand_a;
   logic [DATA_WIDTH-1:0] operand_b;
   logic                  flush;
   logic                  stall_in;
   logic                  stall_req;
   logic                  done;
   logic [DATA_WIDTH-1:0] hi;
   logic [DATA_WIDTH-1:0] lo;

   modport master (
      output valid, funct, operand_a, operand_b, flush, stall_in,
      input  stall_req, done, hi, lo
   );

   modport slave (
      input  valid, funct, operand_a, operand_b, flush, stall_in,
      output stall_req, done, hi, lo
   );
endinterface

// File: rtl/ex_divider.sv
// Multi-cycle restoring divider for DIV/DIVU in EX; stalls the front of the
// pipeline while iterating and presents quotient (lo) / remainder (hi).
module ex_divider #(
   parameter int          DATA_WIDTH = 32,
   parameter int          CNT_WIDTH  = 6,
   parameter logic [5:0]  FUNCT_DIV  = 6'h1A,
   parameter logic [5:0]  FUNCT_DIVU = 6'h1B
) (
   input  logic        clk,
   input  logic        rst,
   ex_divider_if.slave dif
);
   localparam int DW = DATA_WIDTH;
   localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DW - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t               state;
   logic [CNT_WIDTH-1:0] cnt;
   logic [DW:0]          rem;
   logic [DW-1:0]        quot;
   logic [DW-1:0]        divisor;
   logic                 q_neg;
   logic                 r_neg;
   logic [DW-1:0]        hi_q;
   logic [DW-1:0]        lo_q;
   logic                 done_q;

   logic                 is_div;
   logic                 is_signed_op;
   logic                 start;
   logic [DW-1:0]        abs_a;
   logic [DW-1:0]        abs_b;
   logic [DW+1:0]        rem_sh;
   logic [DW:0]          diff;
   logic                 no_borrow;
   logic [DW:0]          rem_nx;
   logic [DW-1:0]        quot_nx;
   logic [DW-1:0]        q_fix;
   logic [DW-1:0]        r_fix;

   assign is_div       = (dif.funct == FUNCT_DIV) || (dif.funct == FUNCT_DIVU);
   assign is_signed_op = (dif.funct == FUNCT_DIV);
   assign start        = dif.valid & ~dif.flush & is_div;

   // Magnitudes for signed ops; -MIN wraps to MIN, which the unsigned
   // iteration then treats as 2^(DW-1), giving the natural overflow result.
   assign abs_a = (is_signed_op && dif.operand_a[DW-1]) ? -dif.operand_a : dif.operand_a;
   assign abs_b = (is_signed_op && dif.operand_b[DW-1]) ? -dif.operand_b : dif.operand_b;

   // One restoring step: shift {rem,quot} left, trial-subtract the divisor.
   always_comb begin
      rem_sh    = {rem, quot[DW-1]};
      no_borrow = (rem_sh >= {2'b00, divisor});
      diff      = rem_sh[DW:0] - {1'b0, divisor};
      rem_nx    = no_borrow ? diff : rem_sh[DW:0];
      quot_nx   = {quot[DW-2:0], no_borrow};
      q_fix     = q_neg ? -quot_nx : quot_nx;
      r_fix     = r_neg ? -rem_nx[DW-1:0] : rem_nx[DW-1:0];
   end

   assign dif.stall_req = ~dif.flush & (((state == IDLE) & start) | (state == BUSY));
   assign dif.done      = done_q;
   assign dif.hi        = hi_q;
   assign dif.lo        = lo_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         rem     <= '0;
         quot    <= '0;
         divisor <= '0;
         q_neg   <= 1'b0;
         r_neg   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else if (dif.flush) begin
         // hi/lo deliberately left untouched on a cancel
         state  <= IDLE;
         done_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (dif.operand_b == '0) begin
                     lo_q   <= '1;
                     hi_q   <= dif.operand_a;
                     done_q <= 1'b1;
                     state  <= DONE;
                  end else begin
                     divisor <= abs_b;
                     quot    <= abs_a;
                     rem     <= '0;
                     cnt     <= '0;
                     q_neg   <= is_signed_op & (dif.operand_a[DW-1] ^ dif.operand_b[DW-1]);
                     r_neg   <= is_signed_op & dif.operand_a[DW-1];
                     state   <= BUSY;
                  end
               end
            end
            BUSY: begin
               rem  <= rem_nx;
               quot <= quot_nx;
               cnt  <= cnt + 1'b1;
               if (cnt == LAST) begin
                  lo_q   <= q_fix;
                  hi_q   <= r_fix;
                  done_q <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               // The DIV still sitting in EX is not re-sampled here.
               if (!dif.stall_in) begin
                  done_q <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               done_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end
endmodule
